// File: rtl/grant_decoder_ctrl.sv
// -----------------------------------------------------------------------------
// grant_decoder_ctrl
//
// Purpose:
//   Sequential grant issuer for the output side of a priority encoder. It
//   accepts an encoded winner index through a valid/ready handshake and drives
//   a registered one-hot grant to that requester. The grant is held until the
//   requester raises done. One dead cycle (GAP) then follows, so two grants
//   never overlap (break-before-make).
//
// Optional feature (macro GRANT_TIMEOUT_EN):
//   When defined, a hold counter force-releases a grant that has been high
//   for HOLD_MAX cycles without done. timeout pulses for one cycle in the
//   first cycle where gnt reads 0. When undefined, no counter exists, a grant
//   is held until done, and timeout is tied low.
//
// Parameters:
//   N         number of requesters / grant lines (>= 2)
//   HOLD_MAX  grant-cycle limit when the timeout is built in (>= 1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_idx    in   encoded winner index
//   req_valid  in   req_idx is valid
//   req_ready  out  block can accept an index (state == IDLE)
//   done       in   current grantee releases its grant
//   gnt        out  registered one-hot grant
//   gnt_idx    out  index of current grant, holds last value when idle
//   busy       out  a grant is active
//   timeout    out  one-cycle pulse when a grant is force-released
// -----------------------------------------------------------------------------
module grant_decoder_ctrl #(
    parameter  int N        = 8,
    parameter  int HOLD_MAX = 15,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] req_idx,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          busy,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Elaboration-time guard on the hold limit.
    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("grant_decoder_ctrl: HOLD_MAX must be at least 1");
    end

    // N widened by one bit so the range check stays meaningful even when N
    // is a power of two (the index can then never be out of range).
    localparam logic [IW:0] N_W = (IW+1)'(N);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  gnt_dec;
    logic          idx_in_range;

    // One-hot decode of the incoming index, one comparator per grant line.
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
        assign gnt_dec[gi] = (req_idx == IW'(gi));
    end

    assign idx_in_range = ({1'b0, req_idx} < N_W);

`ifdef GRANT_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(HOLD_MAX);

    // Counts completed GRANT cycles without done; on the HOLD_MAX-th grant
    // cycle it reads HOLD_MAX-1, which is when the release is scheduled.
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // An out-of-range index still completes the handshake but is
                // dropped without a grant.
                if (req_valid && idx_in_range) begin
                    gnt_d     = gnt_dec;
                    gnt_idx_d = req_idx;
                    busy_d    = 1'b1;
                    state_d   = GRANT;
`ifdef GRANT_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (done) begin
                    // done takes priority over a simultaneous timeout.
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = GAP;
`ifdef GRANT_TIMEOUT_EN
                end else if (cnt_q >= CNT_LAST) begin
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
`ifdef GRANT_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule
